// File: rtl/cr_lz77_comp_tile_match_sel_if.sv
// Handshake bundle between the LZ77 compare tile, the match selector and the
// match-record consumer.
//   master : tile/consumer side (drives tile results, force_done, mr_rdy)
//   slave  : match selector (drives ms_stall and the mr_* record)
interface cr_lz77_comp_tile_match_sel_if #(
  parameter int TRUNC_NUM      = 4,
  parameter int LONGL          = 13,
  parameter int LOG_TILE_DEPTH = 7
);
  logic                              ti_vld;
  logic [TRUNC_NUM*LONGL-1:0]        ti_cl_fwd_therm;
  logic [TRUNC_NUM*LOG_TILE_DEPTH-1:0] ti_cl_offset;
  logic [3:0]                        ti_cl_len4_ind;
  logic                              cl_ti_force_done;
  logic                              ms_stall;
  logic                              mr_vld;
  logic                              mr_rdy;
  logic [LOG_TILE_DEPTH-1:0]         mr_offset;
  logic [8:0]                        mr_len;
  logic [3:0]                        mr_len4_ind;

  modport master (
    output ti_vld, ti_cl_fwd_therm, ti_cl_offset, ti_cl_len4_ind,
           cl_ti_force_done, mr_rdy,
    input  ms_stall, mr_vld, mr_offset, mr_len, mr_len4_ind
  );

  modport slave (
    input  ti_vld, ti_cl_fwd_therm, ti_cl_offset, ti_cl_len4_ind,
           cl_ti_force_done, mr_rdy,
    output ms_stall, mr_vld, mr_offset, mr_len, mr_len4_ind
  );
endinterface

// File: rtl/cr_lz77_comp_tile_match_sel.sv
// LZ77 match selector. Picks the best candidate per tile beat (longest run of
// ones from bit 0, ties to smallest offset then lowest index), stitches
// saturated matches across beats, and queues {offset, len, len4} records.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : tile results in, force_done, ms_stall out,
//                       mr_* record valid/ready out
//   err_overflow      : sticky, a record was dropped on a full FIFO
//   stat_match_cnt    : records accepted into the FIFO
//   stat_cont_cnt     : IDLE->CONT transitions
// Optional: CR_LZ77_COMP_TILE_MATCH_SEL_STATS_EN enables the two counters;
// otherwise they read 0 and no counter flops exist.
module cr_lz77_comp_tile_match_sel #(
  parameter int TRUNC_NUM      = 4,
  parameter int LONGL          = 13,
  parameter int LOG_TILE_DEPTH = 7,
  parameter int MAX_LEN        = 258,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  cr_lz77_comp_tile_match_sel_if.slave bus,
  output logic                         err_overflow,
  output logic [15:0]                  stat_match_cnt,
  output logic [15:0]                  stat_cont_cnt
);
  localparam int NW = $clog2(LONGL + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [NW-1:0] LONGL_N = NW'(LONGL);
  localparam logic [8:0]    MAX_L   = 9'(MAX_LEN);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [LOG_TILE_DEPTH-1:0] offset;
    logic [8:0]                len;
    logic [3:0]                len4;
  } rec_t;

  typedef enum logic {IDLE, CONT} state_t;

  // per-candidate run length and offset
  logic [TRUNC_NUM-1:0][NW-1:0]             cand_n;
  logic [TRUNC_NUM-1:0][LOG_TILE_DEPTH-1:0] cand_off;
  logic                                     run;

  always_comb begin
    cand_n   = '0;
    cand_off = '0;
    run      = 1'b0;
    for (int i = 0; i < TRUNC_NUM; i++) begin
      cand_off[i] = bus.ti_cl_offset[i*LOG_TILE_DEPTH +: LOG_TILE_DEPTH];
      run = 1'b1;
      // only the contiguous run from bit 0 counts; the first 0 ends it
      for (int b = 0; b < LONGL; b++) begin
        if (run && bus.ti_cl_fwd_therm[i*LONGL + b]) cand_n[i] = cand_n[i] + 1'b1;
        else run = 1'b0;
      end
    end
  end

  // best candidate; strict compare keeps the lower index on a full tie
  logic [NW-1:0]             best_n;
  logic [LOG_TILE_DEPTH-1:0] best_off;
  logic [NW-1:0]             m;

  always_comb begin
    best_n   = cand_n[0];
    best_off = cand_off[0];
    for (int i = 1; i < TRUNC_NUM; i++) begin
      if (cand_n[i] > best_n || (cand_n[i] == best_n && cand_off[i] < best_off)) begin
        best_n   = cand_n[i];
        best_off = cand_off[i];
      end
    end
  end

  // FSM, accumulator, latched match
  state_t                    state_q, state_d;
  logic [8:0]                acc_q, acc_d, acc_sat;
  logic [9:0]                acc_wide;
  logic [NW-1:0]             m_eff;
  logic [LOG_TILE_DEPTH-1:0] lat_off_q, lat_off_d;
  logic [3:0]                lat_l4_q, lat_l4_d;
  logic                      push;
  rec_t                      push_rec;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    lat_off_d = lat_off_q;
    lat_l4_d  = lat_l4_q;
    push      = 1'b0;
    push_rec  = '0;
    // continuation length: longest candidate still on the latched offset
    m = '0;
    for (int i = 0; i < TRUNC_NUM; i++)
      if (cand_off[i] == lat_off_q && cand_n[i] > m) m = cand_n[i];
    m_eff    = bus.ti_vld ? m : '0;
    acc_wide = {1'b0, acc_q} + 10'(m_eff);
    acc_sat  = (acc_wide >= {1'b0, MAX_L}) ? MAX_L : acc_wide[8:0];
    case (state_q)
      IDLE: if (bus.ti_vld) begin
        if (best_n == LONGL_N) begin
          state_d   = CONT;
          acc_d     = 9'(LONGL);
          lat_off_d = best_off;
          lat_l4_d  = bus.ti_cl_len4_ind;
        end else if (best_n != '0) begin
          push            = 1'b1;
          push_rec.offset = best_off;
          push_rec.len    = 9'(best_n);
          push_rec.len4   = bus.ti_cl_len4_ind;
        end
      end
      CONT: begin
        if (bus.cl_ti_force_done ||
            (bus.ti_vld && !(m == LONGL_N && acc_sat < MAX_L))) begin
          push            = 1'b1;
          push_rec.offset = lat_off_q;
          push_rec.len    = acc_sat;
          push_rec.len4   = lat_l4_q;
          state_d         = IDLE;
          acc_d           = '0;
        end else if (bus.ti_vld) begin
          acc_d = acc_sat;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // record FIFO; a full FIFO still accepts a push when the head pops
  rec_t [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]           cnt_q, cnt_d;
  logic                  full, pop, wr_en, ovf;
  logic                  ms_stall_q, ms_stall_d;
  logic                  err_q, err_d;

  always_comb begin
    full       = (cnt_q == DEPTH_C);
    pop        = (cnt_q != '0) && bus.mr_rdy;
    wr_en      = push && (!full || pop);
    ovf        = push && full && !pop;
    mem_d      = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = push_rec;
    wr_ptr_d   = wr_ptr_q + PW'(wr_en);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    cnt_d      = cnt_q + (PW+1)'(wr_en) - (PW+1)'(pop);
    // one slot of headroom for a result already in flight
    ms_stall_d = (cnt_d >= DEPTH_C - 1'b1);
    err_d      = err_q | ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      lat_off_q  <= '0;
      lat_l4_q   <= '0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ms_stall_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      lat_off_q  <= lat_off_d;
      lat_l4_q   <= lat_l4_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ms_stall_q <= ms_stall_d;
      err_q      <= err_d;
    end
  end

  assign bus.mr_vld      = (cnt_q != '0);
  assign bus.mr_offset   = mem_q[rd_ptr_q].offset;
  assign bus.mr_len      = mem_q[rd_ptr_q].len;
  assign bus.mr_len4_ind = mem_q[rd_ptr_q].len4;
  assign bus.ms_stall    = ms_stall_q;
  assign err_overflow    = err_q;

`ifdef CR_LZ77_COMP_TILE_MATCH_SEL_STATS_EN
  logic [15:0] match_cnt_q, match_cnt_d, cont_cnt_q, cont_cnt_d;
  logic        cont_start;

  always_comb begin
    cont_start  = (state_q == IDLE) && (state_d == CONT);
    match_cnt_d = match_cnt_q;
    cont_cnt_d  = cont_cnt_q;
    if (wr_en && match_cnt_q != 16'hFFFF) match_cnt_d = match_cnt_q + 16'd1;
    if (cont_start && cont_cnt_q != 16'hFFFF) cont_cnt_d = cont_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt_q <= '0;
      cont_cnt_q  <= '0;
    end else begin
      match_cnt_q <= match_cnt_d;
      cont_cnt_q  <= cont_cnt_d;
    end
  end

  assign stat_match_cnt = match_cnt_q;
  assign stat_cont_cnt  = cont_cnt_q;
`else
  assign stat_match_cnt = '0;
  assign stat_cont_cnt  = '0;
`endif
endmodule

// File: doc/cr_lz77_comp_tile_match_sel.md
Name: cr_lz77_comp_tile_match_sel

Overview:
- Sits directly downstream of the LZ77 compare tile.
- Consumes the tile's per-candidate forward-match thermometers and offsets, selects the best match per beat, and stitches long matches across consecutive beats.
- Emits {offset, length} match records through a small FIFO with a valid/ready handshake.
- Drives a stall signal back toward the tile's shift/input enable logic.

Parameters:
- TRUNC_NUM, 4, candidate matches reported per tile beat
- LONGL, 13, thermometer width; all-ones means saturated, match continues
- LOG_TILE_DEPTH, 7, offset index width
- MAX_LEN, 258, maximum accumulated match length
- FIFO_DEPTH, 4, output record FIFO entries (power of 2, at least 2)

Ports:
- clk  in  1  single clock
- rst  in  1  reset; synchronous and active-high
- ti_vld  in  1  tile result valid this cycle
- ti_cl_fwd_therm  in  TRUNC_NUM*LONGL  per-candidate forward thermometer
- ti_cl_offset  in  TRUNC_NUM*LOG_TILE_DEPTH  per-candidate offset
- ti_cl_len4_ind  in  4  per-lane length-4 indicator
- cl_ti_force_done  in  1  terminate any open continuation
- ms_stall  out  1  upstream must hold tile shift/input
- mr_vld  out  1  match record valid
- mr_rdy  in  1  consumer ready
- mr_offset  out  LOG_TILE_DEPTH  record offset
- mr_len  out  9  record length, 1..MAX_LEN
- mr_len4_ind  out  4  len4 indicator captured with the record
- err_overflow  out  1  sticky; a record was dropped
- stat_match_cnt  out  16  matches emitted (see Optional Feature)
- stat_cont_cnt  out  16  continuation starts (see Optional Feature)

Behaviour:
- Reset values: every output 0; FIFO empty; state IDLE; accumulator 0.
- Candidate length: n = count of contiguous ones from bit 0 of the candidate thermometer (0..LONGL). Bits above the first 0 are ignored. n=0 means no match.
- Selection, combinational on the input beat:
  - best = maximum n.
  - Tie goes to the smallest offset value; a remaining tie goes to the lowest candidate index.
  - Beat with all n=0 produces nothing.
- State machine, advancing only on ti_vld:
  - IDLE: if best n in 1..LONGL-1, push {offset, n, len4_ind}. If best n == LONGL, latch offset/len4_ind, acc = LONGL, go to CONT.
  - CONT: look for a candidate whose offset equals the latched offset; m = its n, or 0 if none.
    - acc_next = min(acc + m, MAX_LEN).
    - If m == LONGL and acc_next < MAX_LEN, stay in CONT.
    - Otherwise push {latched offset, acc_next}, go to IDLE. The beat's other candidates are not re-evaluated.
    - If acc_next == MAX_LEN, push and go to IDLE even when m == LONGL.
  - cl_ti_force_done in CONT (with or without ti_vld): push {offset, acc including this beat's m if ti_vld}, go to IDLE. In IDLE it has no effect.
  - Accumulator is 9 bits with saturating add.
- FIFO and push timing:
  - A push is written to the FIFO at the clock edge ending the input cycle.
  - mr_vld rises on the next cycle, so latency is 1 cycle from ti_vld to mr_vld for an IDLE short match.
  - mr_* are driven from the FIFO head and are stable while mr_vld && !mr_rdy.
  - Pop occurs when mr_vld && mr_rdy.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
- Stall:
  - ms_stall is registered and asserts when occupancy after this cycle's push/pop is ≥ FIFO_DEPTH-1.
  - It leaves one slot for a result already in flight.
- Overflow:
  - A push while the FIFO is full with no simultaneous pop drops the record and sets err_overflow.
  - err_overflow stays set until rst.
  - The state machine still advances normally.
- ti_vld while ms_stall is high is legal and is processed normally.
- rst mid-continuation: the open match is discarded, nothing is emitted, and the FIFO is flushed.

Optional Feature:
- Macro: CR_LZ77_COMP_TILE_MATCH_SEL_STATS_EN.
- Defined:
  - stat_match_cnt increments on every successful push (not on dropped records).
  - stat_cont_cnt increments on each IDLE→CONT transition.
  - Both are 16-bit, saturating at 0xFFFF, and cleared by rst.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Short match: ti_vld, candidate 2 therm=0x007 offset=5, others 0, mr_rdy=1 -> next cycle mr_vld=1, mr_offset=5, mr_len=3; FIFO empties after 1 cycle.
- Tie-break: candidates 0/1 both therm=0x01F with offsets 9 and 4 -> single record offset=4, len=5.
- Continuation: beat1 therm=0x1FFF offset=17; beat2 candidate offset=17 therm=0x1FFF; beat3 offset=17 therm=0x003 -> one record after beat3: offset=17, len=28; nothing after beats 1-2.
- Saturation: 20 consecutive all-ones beats at offset 3 -> record len=258 on beat 20 (acc 247+13 clipped); beat 21 starts fresh from IDLE.
- Backpressure/overflow: mr_rdy=0 with 5 short-match beats, FIFO_DEPTH=4 -> ms_stall high after 3rd push, err_overflow=1 after 5th; drain yields records 1-4 in order.
- Force done and reset: CONT with acc=13, cl_ti_force_done without ti_vld -> record len=13. Separately, rst during CONT -> no record, all outputs 0, stats 0 (STATS_EN).
